window_alarm_array: RTL and testbench
=====================================

Name: window_alarm_array

Overview:
- Parametrised successor to the single-window shatter/alarm block: monitors NUM_ZONES window shatter sensors with per-zone debounce.
- Adds an arm/disarm state machine, per-zone masking and a latched per-zone trip record.
- Drives a timed siren output.
- Sits between the raw window sensor inputs and the house-level alarm/annunciator logic.

Parameters:
- NUM_ZONES, 4, number of window sensor inputs (1..32).
- DEBOUNCE_CYCLES, 3, consecutive high clk cycles before a zone counts as tripped (>=1).
- SIREN_CYCLES, 8, cycles the siren sounds after a (re)trigger (>=1).
- ENTRY_CYCLES, 6, entry-delay length (used only with the optional feature, >=1).

Ports:
- clk  input  1  system clock, all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- shatter  input  NUM_ZONES  raw window sensor, 1 = glass broken/open.
- zone_mask  input  NUM_ZONES  1 = zone bypassed (ignored for arming and alarm).
- arm  input  1  arm request, sampled each cycle.
- disarm  input  1  disarm request, sampled each cycle; has priority over arm.
- armed  output  1  1 in ARMED, ENTRY or ALARM.
- alarm  output  1  latched alarm flag.
- siren  output  1  audible output, time-limited.
- arm_fault  output  1  one-cycle pulse: arm refused.
- zone_latched  output  NUM_ZONES  zones that caused or joined the current alarm.

Behaviour:
- Reset (rst_n=0, asynchronous): state DISARMED; armed, alarm, siren and arm_fault = 0; zone_latched = 0; all debounce and siren/entry counters = 0.
- Debounce runs in every state:
  - Per-zone counter increments while shatter[i]=1, saturating at DEBOUNCE_CYCLES.
  - Counter clears to 0 on any cycle shatter[i]=0.
  - tripped[i] = (count[i]==DEBOUNCE_CYCLES).
  - live[i] = tripped[i] & ~zone_mask[i].
- Timing: shatter[i] rising before edge 1 and held reaches tripped after DEBOUNCE_CYCLES edges. State/outputs react at the next edge, so latency from first sampled high to alarm is DEBOUNCE_CYCLES+1 edges.
- States: DISARMED, ARMED, ALARM (ENTRY only with the optional feature).
- disarm=1, any state: next state DISARMED; clears alarm, siren, zone_latched, siren counter. Debounce counters are unaffected. arm is ignored that cycle.
- DISARMED, arm=1, disarm=0:
  - If |live: stay DISARMED, arm_fault=1 for exactly one cycle.
  - Else go to ARMED, armed=1 from the next cycle.
- ARMED, |live:
  - Go to ALARM.
  - alarm=1, siren=1, zone_latched <= live, siren counter <= SIREN_CYCLES-1.
- ALARM:
  - zone_latched <= zone_latched | live.
  - If live has a bit not already in zone_latched: reload siren counter to SIREN_CYCLES-1 and siren=1 (re-trigger).
  - Otherwise siren stays 1 while the counter is nonzero, the counter decrements, and siren drops to 0 on the cycle after it reaches 0.
  - alarm stays 1 until disarm; arm is ignored.
- zone_mask changes take effect combinationally on live the same cycle. Masking a zone does not clear zone_latched.
- arm held high for multiple cycles: no effect beyond the first transition. A held arm with a fault pulses arm_fault every cycle.
- All outputs are registered.

Optional Feature:
- Macro: WINDOW_ALARM_ENTRY_DELAY_EN.
- Defined:
  - Zone 0 is a delayed (entry) zone. In ARMED, live[0] alone enters ENTRY with the entry counter <= ENTRY_CYCLES-1; armed=1, alarm=0, siren=0.
  - In ENTRY, disarm goes to DISARMED.
  - Counter expiry goes to ALARM with zone_latched[0]=1.
  - Any live[i], i>0, during ENTRY goes to ALARM immediately with zone_latched <= live|1.
- Not defined: ENTRY does not exist and zone 0 behaves as any other zone.

Test Plan:
- Reset then arm=1 one cycle with shatter=0 -> armed=1 next cycle, alarm=0, arm_fault=0.
- Armed; shatter=4'b0010 held -> alarm=1 and siren=1 exactly 4 edges after the first sampled high; zone_latched=4'b0010; siren=0 after 8 cycles; alarm stays 1.
- Armed; shatter[1] pulses high for 2 cycles then low -> no alarm; counter clears; alarm=0 throughout.
- Disarmed with shatter[2] held high -> arm pulse gives arm_fault=1 for one cycle and armed=0. Set zone_mask=4'b0100 and arm again -> armed=1.
- In ALARM after the siren has timed out, trip zone 3 -> siren=1 again for 8 cycles; zone_latched=4'b1010. Then disarm=1 together with arm=1 -> DISARMED, all outputs 0.
- rst_n low mid-ALARM (asynchronously, between edges) -> alarm, siren and zone_latched = 0 immediately. With WINDOW_ALARM_ENTRY_DELAY_EN: armed, trip zone 0 -> alarm at ENTRY_CYCLES later unless disarm is asserted earlier.

Source files
------------

// File: rtl/window_alarm_array.sv
// rtl/window_alarm_array.sv - multi-zone window shatter alarm: per-zone debounce, arm/disarm FSM, latched trips, timed siren.
// Optional entry delay on zone 0 when WINDOW_ALARM_ENTRY_DELAY_EN is defined.
module window_alarm_array #(
  parameter int NUM_ZONES       = 4,
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int SIREN_CYCLES    = 8,
  parameter int ENTRY_CYCLES    = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_ZONES-1:0] shatter,
  input  logic [NUM_ZONES-1:0] zone_mask,
  input  logic                 arm,
  input  logic                 disarm,
  output logic                 armed,
  output logic                 alarm,
  output logic                 siren,
  output logic                 arm_fault,
  output logic [NUM_ZONES-1:0] zone_latched
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(SIREN_CYCLES + 1);
  localparam logic [DW-1:0] DB_MAX     = DW'(DEBOUNCE_CYCLES);
  localparam logic [SW-1:0] SIREN_LOAD = SW'(SIREN_CYCLES - 1);

  localparam logic [1:0] ST_DISARMED = 2'd0;
  localparam logic [1:0] ST_ARMED    = 2'd1;
  localparam logic [1:0] ST_ALARM    = 2'd2;
`ifdef WINDOW_ALARM_ENTRY_DELAY_EN
  localparam logic [1:0] ST_ENTRY    = 2'd3;
  localparam int EW = $clog2(ENTRY_CYCLES + 1);
  localparam logic [EW-1:0] ENTRY_LOAD = EW'(ENTRY_CYCLES - 1);
  localparam logic [NUM_ZONES-1:0] ZONE0 = NUM_ZONES'(1);
`endif

  logic [DW-1:0]          cnt_q [NUM_ZONES];
  logic [DW-1:0]          cnt_d [NUM_ZONES];
  logic [NUM_ZONES-1:0]   tripped;
  logic [NUM_ZONES-1:0]   live;

  logic [1:0]             state_q, state_d;
  logic                   armed_q, armed_d;
  logic                   alarm_q, alarm_d;
  logic                   siren_q, siren_d;
  logic                   arm_fault_q, arm_fault_d;
  logic [NUM_ZONES-1:0]   zone_latched_q, zone_latched_d;
  logic [SW-1:0]          siren_cnt_q, siren_cnt_d;
  logic [NUM_ZONES-1:0]   fresh;
`ifdef WINDOW_ALARM_ENTRY_DELAY_EN
  logic [EW-1:0]          entry_cnt_q, entry_cnt_d;
  logic [NUM_ZONES-1:0]   live_hi;
`endif

  // Debounce runs regardless of FSM state so arming sees an already-settled view.
  always_comb begin
    for (int i = 0; i < NUM_ZONES; i++) begin
      cnt_d[i] = '0;
      if (shatter[i]) begin
        cnt_d[i] = (cnt_q[i] == DB_MAX) ? cnt_q[i] : cnt_q[i] + DW'(1);
      end
      tripped[i] = (cnt_q[i] == DB_MAX);
    end
    live = tripped & ~zone_mask;
  end

  always_comb begin
    state_d        = state_q;
    alarm_d        = alarm_q;
    siren_d        = siren_q;
    arm_fault_d    = 1'b0;
    zone_latched_d = zone_latched_q;
    siren_cnt_d    = siren_cnt_q;
    fresh          = live & ~zone_latched_q;
`ifdef WINDOW_ALARM_ENTRY_DELAY_EN
    entry_cnt_d    = entry_cnt_q;
    live_hi        = live & ~ZONE0;
`endif
    if (disarm) begin
      state_d        = ST_DISARMED;
      alarm_d        = 1'b0;
      siren_d        = 1'b0;
      zone_latched_d = '0;
      siren_cnt_d    = '0;
`ifdef WINDOW_ALARM_ENTRY_DELAY_EN
      entry_cnt_d    = '0;
`endif
    end else begin
      case (state_q)
        ST_DISARMED: begin
          if (arm) begin
            if (|live) arm_fault_d = 1'b1;
            else       state_d     = ST_ARMED;
          end
        end
        ST_ARMED: begin
`ifdef WINDOW_ALARM_ENTRY_DELAY_EN
          if (|live_hi) begin
            state_d        = ST_ALARM;
            alarm_d        = 1'b1;
            siren_d        = 1'b1;
            zone_latched_d = live;
            siren_cnt_d    = SIREN_LOAD;
          end else if (|live) begin
            state_d     = ST_ENTRY;
            entry_cnt_d = ENTRY_LOAD;
          end
`else
          if (|live) begin
            state_d        = ST_ALARM;
            alarm_d        = 1'b1;
            siren_d        = 1'b1;
            zone_latched_d = live;
            siren_cnt_d    = SIREN_LOAD;
          end
`endif
        end
`ifdef WINDOW_ALARM_ENTRY_DELAY_EN
        ST_ENTRY: begin
          // An instant zone overrides the entry grace period.
          if (|live_hi || entry_cnt_q == '0) begin
            state_d        = ST_ALARM;
            alarm_d        = 1'b1;
            siren_d        = 1'b1;
            zone_latched_d = (|live_hi) ? (live | ZONE0) : ZONE0;
            siren_cnt_d    = SIREN_LOAD;
          end else begin
            entry_cnt_d = entry_cnt_q - EW'(1);
          end
        end
`endif
        ST_ALARM: begin
          zone_latched_d = zone_latched_q | live;
          if (|fresh) begin
            siren_d     = 1'b1;
            siren_cnt_d = SIREN_LOAD;
          end else if (siren_cnt_q != '0) begin
            siren_cnt_d = siren_cnt_q - SW'(1);
          end else begin
            siren_d = 1'b0;
          end
        end
        default: begin
          state_d        = ST_DISARMED;
          alarm_d        = 1'b0;
          siren_d        = 1'b0;
          zone_latched_d = '0;
          siren_cnt_d    = '0;
        end
      endcase
    end
    armed_d = (state_d != ST_DISARMED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ZONES; i++) cnt_q[i] <= '0;
      state_q        <= ST_DISARMED;
      armed_q        <= 1'b0;
      alarm_q        <= 1'b0;
      siren_q        <= 1'b0;
      arm_fault_q    <= 1'b0;
      zone_latched_q <= '0;
      siren_cnt_q    <= '0;
`ifdef WINDOW_ALARM_ENTRY_DELAY_EN
      entry_cnt_q    <= '0;
`endif
    end else begin
      for (int i = 0; i < NUM_ZONES; i++) cnt_q[i] <= cnt_d[i];
      state_q        <= state_d;
      armed_q        <= armed_d;
      alarm_q        <= alarm_d;
      siren_q        <= siren_d;
      arm_fault_q    <= arm_fault_d;
      zone_latched_q <= zone_latched_d;
      siren_cnt_q    <= siren_cnt_d;
`ifdef WINDOW_ALARM_ENTRY_DELAY_EN
      entry_cnt_q    <= entry_cnt_d;
`endif
    end
  end

  assign armed        = armed_q;
  assign alarm        = alarm_q;
  assign siren        = siren_q;
  assign arm_fault    = arm_fault_q;
  assign zone_latched = zone_latched_q;

endmodule

// File: tb/tb_window_alarm_array.sv
// tb/tb_window_alarm_array.sv - self-checking bench for window_alarm_array against a timestamp-based reference model.
module tb_window_alarm_array;
  localparam int NZ = 4;
  localparam int DB = 3;
  localparam int SC = 8;
  localparam int EC = 6;

  localparam int M_DIS = 0;
  localparam int M_ARM = 1;
  localparam int M_ALM = 2;
  localparam int M_ENT = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NZ-1:0] shatter = '0;
  logic [NZ-1:0] zone_mask = '0;
  logic          arm = 1'b0;
  logic          disarm = 1'b0;
  logic          armed, alarm, siren, arm_fault;
  logic [NZ-1:0] zone_latched;

  int checks = 0;
  int failures = 0;

  // Reference model: run lengths per zone, deadlines as absolute edge numbers.
  int            m_state;
  int            run [NZ];
  logic          m_armed, m_alarm, m_siren, m_fault;
  logic [NZ-1:0] m_zl;
  int            edge_n = 0;
  int            siren_end, entry_end;

  window_alarm_array #(
    .NUM_ZONES(NZ), .DEBOUNCE_CYCLES(DB), .SIREN_CYCLES(SC), .ENTRY_CYCLES(EC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .shatter(shatter), .zone_mask(zone_mask),
    .arm(arm), .disarm(disarm), .armed(armed), .alarm(alarm), .siren(siren),
    .arm_fault(arm_fault), .zone_latched(zone_latched)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = M_DIS;
    for (int i = 0; i < NZ; i++) run[i] = 0;
    m_armed = 0; m_alarm = 0; m_siren = 0; m_fault = 0; m_zl = '0;
    siren_end = 0; entry_end = 0;
  endtask

  task automatic go_alarm(input logic [NZ-1:0] zones);
    m_state = M_ALM; m_alarm = 1; m_zl = zones; siren_end = edge_n + SC;
  endtask

  task automatic model_edge();
    logic [NZ-1:0] live;
    logic [NZ-1:0] fresh;
    edge_n++;
    live = '0;
    for (int i = 0; i < NZ; i++) if (run[i] >= DB && !zone_mask[i]) live[i] = 1'b1;
    m_fault = 0;
    if (disarm) begin
      m_state = M_DIS; m_alarm = 0; m_zl = '0; siren_end = 0;
    end else begin
      case (m_state)
        M_DIS: if (arm) begin
          if (live != 0) m_fault = 1;
          else m_state = M_ARM;
        end
        M_ARM: if (live != 0) begin
`ifdef WINDOW_ALARM_ENTRY_DELAY_EN
          if (live == NZ'(1)) begin m_state = M_ENT; entry_end = edge_n + EC; end
          else go_alarm(live);
`else
          go_alarm(live);
`endif
        end
        M_ENT: begin
          if ((live >> 1) != 0) go_alarm(live | NZ'(1));
          else if (edge_n >= entry_end) go_alarm(NZ'(1));
        end
        default: begin
          fresh = live & ~m_zl;
          m_zl = m_zl | live;
          if (fresh != 0) siren_end = edge_n + SC;
        end
      endcase
    end
    m_armed = (m_state != M_DIS);
    m_siren = (m_state == M_ALM) && (edge_n < siren_end);
    for (int i = 0; i < NZ; i++) run[i] = shatter[i] ? ((run[i] < 1000) ? run[i] + 1 : run[i]) : 0;
  endtask

  task automatic step(input logic [NZ-1:0] sh, input logic [NZ-1:0] mk, input logic a, input logic d);
    @(negedge clk);
    shatter = sh; zone_mask = mk; arm = a; disarm = d;
    @(posedge clk);
    model_edge();
    #1;
    checks++; if (armed !== m_armed) begin failures++; $display("FAIL armed edge=%0d got=%b exp=%b", edge_n, armed, m_armed); end
    checks++; if (alarm !== m_alarm) begin failures++; $display("FAIL alarm edge=%0d got=%b exp=%b", edge_n, alarm, m_alarm); end
    checks++; if (siren !== m_siren) begin failures++; $display("FAIL siren edge=%0d got=%b exp=%b", edge_n, siren, m_siren); end
    checks++; if (arm_fault !== m_fault) begin failures++; $display("FAIL arm_fault edge=%0d got=%b exp=%b", edge_n, arm_fault, m_fault); end
    checks++; if (zone_latched !== m_zl) begin failures++; $display("FAIL zone_latched edge=%0d got=%b exp=%b", edge_n, zone_latched, m_zl); end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({armed, alarm, siren, arm_fault, zone_latched} !== '0) begin
      failures++; $display("FAIL reset_outputs got=%b exp=0", {armed, alarm, siren, arm_fault, zone_latched});
    end
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_arm();
    step('0, '0, 1, 0);
    checks++; if (armed !== 1'b1 || arm_fault !== 1'b0 || alarm !== 1'b0) begin
      failures++; $display("FAIL arm_basic got armed=%b fault=%b alarm=%b exp 1/0/0", armed, arm_fault, alarm);
    end
    step('0, '0, 0, 0);
  endtask

  task automatic test_trip_siren();
    int first = -1;
    int siren_n = 0;
    for (int k = 1; k <= 14; k++) begin
      step(4'b0010, '0, 0, 0);
      if (alarm === 1'b1 && first < 0) first = k;
      if (siren === 1'b1) siren_n++;
    end
    checks++; if (first != DB + 1) begin failures++; $display("FAIL trip_latency got=%0d exp=%0d", first, DB + 1); end
    checks++; if (siren_n != SC) begin failures++; $display("FAIL siren_len got=%0d exp=%0d", siren_n, SC); end
    checks++; if (zone_latched !== 4'b0010 || alarm !== 1'b1) begin
      failures++; $display("FAIL trip_latch got zl=%b alarm=%b exp 0010/1", zone_latched, alarm);
    end
    repeat (2) step('0, '0, 0, 0);
  endtask

  task automatic test_retrigger();
    int siren_n = 0;
    step(4'b1000, '0, 1, 0);
    for (int k = 0; k < DB + SC + 3; k++) begin
      step(4'b1000, '0, 0, 0);
      if (siren === 1'b1) siren_n++;
    end
    checks++; if (siren_n != SC) begin failures++; $display("FAIL retrig_siren_len got=%0d exp=%0d", siren_n, SC); end
    checks++; if (zone_latched !== 4'b1010) begin failures++; $display("FAIL retrig_latch got=%b exp=1010", zone_latched); end
    step('0, '0, 1, 1);
    checks++; if ({armed, alarm, siren, arm_fault, zone_latched} !== '0) begin
      failures++; $display("FAIL disarm_prio got=%b exp=0", {armed, alarm, siren, arm_fault, zone_latched});
    end
  endtask

  task automatic test_glitch();
    int seen = 0;
    step('0, '0, 1, 0);
    step(4'b0010, '0, 0, 0);
    step(4'b0010, '0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      step('0, '0, 0, 0);
      if (alarm !== 1'b0) seen++;
    end
    checks++; if (seen != 0 || armed !== 1'b1) begin
      failures++; $display("FAIL glitch got alarm_cycles=%0d armed=%b exp 0/1", seen, armed);
    end
    step('0, '0, 0, 1);
  endtask

  task automatic test_arm_fault();
    repeat (DB) step(4'b0100, '0, 0, 0);
    step(4'b0100, '0, 1, 0);
    checks++; if (arm_fault !== 1'b1 || armed !== 1'b0) begin
      failures++; $display("FAIL fault_pulse got fault=%b armed=%b exp 1/0", arm_fault, armed);
    end
    step(4'b0100, '0, 0, 0);
    checks++; if (arm_fault !== 1'b0) begin failures++; $display("FAIL fault_one_cycle got=%b exp=0", arm_fault); end
    step(4'b0100, 4'b0100, 1, 0);
    checks++; if (armed !== 1'b1) begin failures++; $display("FAIL masked_arm got=%b exp=1", armed); end
    step(4'b0100, 4'b0100, 0, 0);
    checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL masked_no_alarm got=%b exp=0", alarm); end
    step('0, '0, 0, 1);
  endtask

  task automatic test_async_reset();
    step('0, '0, 1, 0);
    repeat (DB + 2) step(4'b0010, '0, 0, 0);
    checks++; if (alarm !== 1'b1) begin failures++; $display("FAIL pre_reset_alarm got=%b exp=1", alarm); end
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    checks++; if ({armed, alarm, siren, zone_latched} !== '0) begin
      failures++; $display("FAIL async_reset got=%b exp=0", {armed, alarm, siren, zone_latched});
    end
    model_reset();
    shatter = '0;
    @(negedge clk);
    rst_n = 1;
  endtask

`ifdef WINDOW_ALARM_ENTRY_DELAY_EN
  task automatic test_entry();
    int first = -1;
    int seen = 0;
    step('0, '0, 1, 0);
    for (int k = 1; k <= DB + EC + 3; k++) begin
      step(4'b0001, '0, 0, 0);
      if (alarm === 1'b1 && first < 0) first = k;
    end
    checks++; if (first != DB + 1 + EC) begin failures++; $display("FAIL entry_latency got=%0d exp=%0d", first, DB + 1 + EC); end
    step('0, '0, 0, 1);
    step('0, '0, 1, 0);
    repeat (DB + 3) begin
      step(4'b0001, '0, 0, 0);
      if (alarm !== 1'b0) seen++;
    end
    step(4'b0001, '0, 0, 1);
    repeat (4) step('0, '0, 0, 0);
    checks++; if (seen != 0 || alarm !== 1'b0) begin
      failures++; $display("FAIL entry_disarm got alarm_cycles=%0d alarm=%b exp 0/0", seen, alarm);
    end
  endtask
`endif

  task automatic test_random();
    logic [NZ-1:0] sh = '0;
    logic [NZ-1:0] mk = '0;
    logic a, d;
    for (int n = 0; n < 800; n++) begin
      for (int z = 0; z < NZ; z++) if ($urandom_range(0, 5) == 0) sh[z] = ~sh[z];
      if ($urandom_range(0, 40) == 0) mk = NZ'($urandom);
      a = ($urandom_range(0, 4) == 0);
      d = ($urandom_range(0, 30) == 0);
      step(sh, mk, a, d);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_arm();
    test_trip_siren();
    test_retrigger();
    test_glitch();
    test_arm_fault();
    test_async_reset();
`ifdef WINDOW_ALARM_ENTRY_DELAY_EN
    test_entry();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
